// File: rtl/lbuf_read_timing.sv
// lbuf_read_timing
//   Output-side raster generator and line-buffer read addresser for the scan
//   converter. An internal raster (hcnt/vcnt plus the sub-pixel/sub-line
//   phase counters and line-buffer column/line indices) advances every
//   PCLK_out cycle. All outputs are registered copies of that raster, or are
//   decoded from it, so every output describes the same pixel one cycle later.
//
//   Optional feature (macro FRAMELOCK_EN): VSYNC_in is synchronised and its
//   falling edge arms a pending lock. The next output line wrap then loads
//   vcnt with V_LOCK_LINE instead of vcnt+1 and pulses lock_event. With the
//   macro undefined the raster free-runs, VSYNC_in is ignored and lock_event
//   stays 0.
//
// Ports
//   PCLK_out       in   output pixel clock
//   reset_n        in   async active-low reset
//   VSYNC_in       in   source VSYNC, active-low, asynchronous to PCLK_out
//   hcnt_ext       out  output pixel counter 0..H_TOTAL-1
//   vcnt_ext       out  output line counter 0..V_TOTAL-1
//   hcnt_ext_lbuf  out  line-buffer column 0..SRC_H_ACTIVE-1
//   vcnt_ext_lbuf  out  line-buffer line index 0..NUM_LINE_BUFFERS-1
//   hctr_ext       out  sub-pixel phase 0..H_SCALE-1
//   vctr_ext       out  sub-line phase 0..V_SCALE-1
//   HSYNC_ext      out  active-low horizontal sync
//   VSYNC_ext      out  active-low vertical sync
//   DE_ext         out  data enable over the active area
//   lock_event     out  one-cycle pulse on the pixel where vcnt was reloaded
module lbuf_read_timing #(
  parameter int H_TOTAL          = 1650,
  parameter int H_ACTIVE         = 1280,
  parameter int H_SYNCLEN        = 40,
  parameter int H_BACKPORCH      = 220,
  parameter int V_TOTAL          = 750,
  parameter int V_ACTIVE         = 720,
  parameter int V_SYNCLEN        = 5,
  parameter int V_BACKPORCH      = 20,
  parameter int H_SCALE          = 3,
  parameter int V_SCALE          = 3,
  parameter int H_OFFSET         = 64,
  parameter int V_OFFSET         = 24,
  parameter int SRC_H_ACTIVE     = 384,
  parameter int NUM_LINE_BUFFERS = 40,
  parameter int V_LOCK_LINE      = 740
) (
  input  logic        PCLK_out,
  input  logic        reset_n,
  input  logic        VSYNC_in,
  output logic [10:0] hcnt_ext,
  output logic [10:0] vcnt_ext,
  output logic [8:0]  hcnt_ext_lbuf,
  output logic [5:0]  vcnt_ext_lbuf,
  output logic [2:0]  hctr_ext,
  output logic [2:0]  vctr_ext,
  output logic        HSYNC_ext,
  output logic        VSYNC_ext,
  output logic        DE_ext,
  output logic        lock_event
);

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SYNC_E  = 11'(H_SYNCLEN);
  localparam logic [10:0] H_ACT_BEG = 11'(H_SYNCLEN + H_BACKPORCH);
  localparam logic [10:0] H_ACT_END = 11'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
  localparam logic [10:0] H_WIN_BEG = 11'(H_SYNCLEN + H_BACKPORCH + H_OFFSET);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_SYNC_E  = 11'(V_SYNCLEN);
  localparam logic [10:0] V_ACT_BEG = 11'(V_SYNCLEN + V_BACKPORCH);
  localparam logic [10:0] V_ACT_END = 11'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);
  localparam logic [10:0] V_WIN_BEG = 11'(V_SYNCLEN + V_BACKPORCH + V_OFFSET);
  localparam logic [10:0] V_LOCK    = 11'(V_LOCK_LINE);
  localparam logic [2:0]  HCTR_LAST = 3'(H_SCALE - 1);
  localparam logic [2:0]  VCTR_LAST = 3'(V_SCALE - 1);
  localparam logic [8:0]  HLB_LAST  = 9'(SRC_H_ACTIVE - 1);
  localparam logic [5:0]  VLB_LAST  = 6'(NUM_LINE_BUFFERS - 1);

  // internal raster, one cycle ahead of the registered outputs
  logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [2:0]  hctr_q, hctr_d, vctr_q, vctr_d;
  logic [8:0]  hlb_q, hlb_d;
  logic [5:0]  vlb_q, vlb_d;
  logic        lock_hit_q, lock_hit_d;
  logic        line_end, lock_take;

  // registered outputs
  logic [10:0] hcnt_ext_q, hcnt_ext_d, vcnt_ext_q, vcnt_ext_d;
  logic [8:0]  hlb_ext_q, hlb_ext_d;
  logic [5:0]  vlb_ext_q, vlb_ext_d;
  logic [2:0]  hctr_ext_q, hctr_ext_d, vctr_ext_q, vctr_ext_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic        lock_event_q, lock_event_d;

  assign line_end = (hcnt_q == H_LAST);

`ifdef FRAMELOCK_EN
  logic vs_meta_q, vs_meta_d, vs_sync_q, vs_sync_d, vs_prev_q, vs_prev_d;
  logic lock_pending_q, lock_pending_d;

  always_comb begin
    vs_meta_d = VSYNC_in;
    vs_sync_d = vs_meta_q;
    vs_prev_d = vs_sync_q;
    lock_take = line_end & lock_pending_q;
    // a fresh falling edge wins over consumption, so it re-arms the lock
    lock_pending_d = (vs_prev_q & ~vs_sync_q) | (lock_pending_q & ~lock_take);
  end

  always_ff @(posedge PCLK_out or negedge reset_n) begin
    if (!reset_n) begin
      vs_meta_q      <= 1'b1;
      vs_sync_q      <= 1'b1;
      vs_prev_q      <= 1'b1;
      lock_pending_q <= 1'b0;
    end else begin
      vs_meta_q      <= vs_meta_d;
      vs_sync_q      <= vs_sync_d;
      vs_prev_q      <= vs_prev_d;
      lock_pending_q <= lock_pending_d;
    end
  end
`else
  logic unused_vsync_in;
  assign unused_vsync_in = VSYNC_in;
  assign lock_take       = 1'b0;
`endif

  always_comb begin
    hcnt_d     = line_end ? 11'd0 : hcnt_q + 11'd1;
    vcnt_d     = vcnt_q;
    lock_hit_d = 1'b0;
    if (line_end) begin
      if (lock_take) begin
        vcnt_d     = V_LOCK;
        lock_hit_d = 1'b1;
      end else begin
        vcnt_d = (vcnt_q == V_LAST) ? 11'd0 : vcnt_q + 11'd1;
      end
    end

    // horizontal read window: active-relative H_OFFSET to end of active
    hctr_d = 3'd0;
    hlb_d  = 9'd0;
    if (hcnt_d > H_WIN_BEG && hcnt_d < H_ACT_END) begin
      if (hctr_q == HCTR_LAST) begin
        hlb_d = (hlb_q == HLB_LAST) ? hlb_q : hlb_q + 9'd1;
      end else begin
        hctr_d = hctr_q + 3'd1;
        hlb_d  = hlb_q;
      end
    end

    // vertical read window advances only on line wraps; the ring index wraps
    vctr_d = vctr_q;
    vlb_d  = vlb_q;
    if (line_end) begin
      vctr_d = 3'd0;
      vlb_d  = 6'd0;
      if (vcnt_d > V_WIN_BEG && vcnt_d < V_ACT_END) begin
        if (vctr_q == VCTR_LAST) begin
          vlb_d = (vlb_q == VLB_LAST) ? 6'd0 : vlb_q + 6'd1;
        end else begin
          vctr_d = vctr_q + 3'd1;
          vlb_d  = vlb_q;
        end
      end
    end

    hcnt_ext_d   = hcnt_q;
    vcnt_ext_d   = vcnt_q;
    hlb_ext_d    = hlb_q;
    vlb_ext_d    = vlb_q;
    hctr_ext_d   = hctr_q;
    vctr_ext_d   = vctr_q;
    hsync_d      = (hcnt_q >= H_SYNC_E);
    vsync_d      = (vcnt_q >= V_SYNC_E);
    de_d         = (hcnt_q >= H_ACT_BEG) && (hcnt_q < H_ACT_END) &&
                   (vcnt_q >= V_ACT_BEG) && (vcnt_q < V_ACT_END);
    lock_event_d = lock_hit_q;
  end

  always_ff @(posedge PCLK_out or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      hctr_q       <= '0;
      vctr_q       <= '0;
      hlb_q        <= '0;
      vlb_q        <= '0;
      lock_hit_q   <= 1'b0;
      hcnt_ext_q   <= '0;
      vcnt_ext_q   <= '0;
      hlb_ext_q    <= '0;
      vlb_ext_q    <= '0;
      hctr_ext_q   <= '0;
      vctr_ext_q   <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      de_q         <= 1'b0;
      lock_event_q <= 1'b0;
    end else begin
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      hctr_q       <= hctr_d;
      vctr_q       <= vctr_d;
      hlb_q        <= hlb_d;
      vlb_q        <= vlb_d;
      lock_hit_q   <= lock_hit_d;
      hcnt_ext_q   <= hcnt_ext_d;
      vcnt_ext_q   <= vcnt_ext_d;
      hlb_ext_q    <= hlb_ext_d;
      vlb_ext_q    <= vlb_ext_d;
      hctr_ext_q   <= hctr_ext_d;
      vctr_ext_q   <= vctr_ext_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      de_q         <= de_d;
      lock_event_q <= lock_event_d;
    end
  end

  assign hcnt_ext      = hcnt_ext_q;
  assign vcnt_ext      = vcnt_ext_q;
  assign hcnt_ext_lbuf = hlb_ext_q;
  assign vcnt_ext_lbuf = vlb_ext_q;
  assign hctr_ext      = hctr_ext_q;
  assign vctr_ext      = vctr_ext_q;
  assign HSYNC_ext     = hsync_q;
  assign VSYNC_ext     = vsync_q;
  assign DE_ext        = de_q;
  assign lock_event    = lock_event_q;

endmodule

// File: tb/tb_lbuf_read_timing.sv
// Bench for lbuf_read_timing. A scaled-down raster instance is checked every
// cycle against a position-based reference (expected outputs derived from the
// pixel/line position with division and modulo); a default-parameter instance
// is checked at the named horizontal window points of the full-size raster.
module tb_lbuf_read_timing;
  localparam int HT = 60, HA = 40, HS = 4, HBP = 8;
  localparam int VT = 60, VA = 50, VS = 2, VBP = 4;
  localparam int HSC = 3, VSC = 3, HOFF = 4, VOFF = 2;
  localparam int SRC = 10, NLB = 4, VLOCK = 58;

  logic PCLK_out = 1'b0;
  logic reset_n  = 1'b0;
  logic VSYNC_in = 1'b1;
  logic vs_tie   = 1'b1;
  always #5 PCLK_out = ~PCLK_out;

  logic [10:0] s_hcnt, s_vcnt, d_hcnt, d_vcnt;
  logic [8:0]  s_hlb, d_hlb;
  logic [5:0]  s_vlb, d_vlb;
  logic [2:0]  s_hctr, s_vctr, d_hctr, d_vctr;
  logic        s_hs, s_vs, s_de, s_lock, d_hs, d_vs, d_de, d_lock;

  lbuf_read_timing #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNCLEN(HS), .H_BACKPORCH(HBP),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNCLEN(VS), .V_BACKPORCH(VBP),
    .H_SCALE(HSC), .V_SCALE(VSC), .H_OFFSET(HOFF), .V_OFFSET(VOFF),
    .SRC_H_ACTIVE(SRC), .NUM_LINE_BUFFERS(NLB), .V_LOCK_LINE(VLOCK)
  ) u_dut (
    .PCLK_out(PCLK_out), .reset_n(reset_n), .VSYNC_in(VSYNC_in),
    .hcnt_ext(s_hcnt), .vcnt_ext(s_vcnt), .hcnt_ext_lbuf(s_hlb),
    .vcnt_ext_lbuf(s_vlb), .hctr_ext(s_hctr), .vctr_ext(s_vctr),
    .HSYNC_ext(s_hs), .VSYNC_ext(s_vs), .DE_ext(s_de), .lock_event(s_lock)
  );

  lbuf_read_timing u_dflt (
    .PCLK_out(PCLK_out), .reset_n(reset_n), .VSYNC_in(vs_tie),
    .hcnt_ext(d_hcnt), .vcnt_ext(d_vcnt), .hcnt_ext_lbuf(d_hlb),
    .vcnt_ext_lbuf(d_vlb), .hctr_ext(d_hctr), .vctr_ext(d_vctr),
    .HSYNC_ext(d_hs), .VSYNC_ext(d_vs), .DE_ext(d_de), .lock_event(d_lock)
  );

  logic [46:0] act_vec;
  assign act_vec = {s_hcnt, s_vcnt, s_hlb, s_vlb, s_hctr, s_vctr, s_hs, s_vs, s_de, s_lock};

  int total = 0;
  int bad   = 0;

  // reference raster position of what the outputs currently show
  int mh, mv, cyc;
  bit live, mlk, arm;

  always @(posedge PCLK_out or negedge reset_n) begin
    if (!reset_n) begin
      live = 0; mlk = 0; arm = 0; mh = 0; mv = 0; cyc = 0;
    end else begin
      cyc = cyc + 1;
      mlk = 0;
      if (!live) begin
        live = 1; mh = 0; mv = 0;
      end else if (mh == HT - 1) begin
        mh = 0;
        if (arm) begin
          mv = VLOCK; mlk = 1; arm = 0;
        end else begin
          mv = (mv + 1) % VT;
        end
      end else begin
        mh = mh + 1;
      end
    end
  end

  function automatic logic [46:0] exp_vec();
    int hr, vr, hd, vd, hl, vl, hc, vc;
    bit de;
    if (!live) return {11'd0, 11'd0, 9'd0, 6'd0, 3'd0, 3'd0, 4'b1100};
    hr = mh - (HS + HBP);
    vr = mv - (VS + VBP);
    de = (hr >= 0 && hr < HA && vr >= 0 && vr < VA);
    hl = 0; hc = 0; vl = 0; vc = 0;
    if (hr >= HOFF && hr < HA) begin
      hd = hr - HOFF; hc = hd % HSC; hl = hd / HSC;
      if (hl > SRC - 1) hl = SRC - 1;
    end
    if (vr >= VOFF && vr < VA) begin
      vd = vr - VOFF; vc = vd % VSC; vl = (vd / VSC) % NLB;
    end
    return {11'(mh), 11'(mv), 9'(hl), 6'(vl), 3'(hc), 3'(vc),
            1'(mh >= HS), 1'(mv >= VS), de, mlk};
  endfunction

  task automatic tick();
    @(negedge PCLK_out);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL reset_state got=%h exp=%h", act_vec, exp_vec());
      end
      total++;
    end
    reset_n = 1'b1;
    tick();
    if ({s_hcnt, s_hs} !== {11'd0, 1'b0}) begin
      bad++; $display("FAIL first_cycle hcnt=%0d hsync=%b exp 0/0", s_hcnt, s_hs);
    end
    total++;
    if ({d_hcnt, d_hs, d_de} !== {11'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL first_cycle_dflt hcnt=%0d hsync=%b de=%b exp 0/0/0", d_hcnt, d_hs, d_de);
    end
    total++;
  endtask

  task automatic test_frame();
    int hs_lo, vs_lo, de_hi;
    hs_lo = 0; vs_lo = 0; de_hi = 0;
    for (int n = 0; n < HT * VT; n++) begin
      if (n > 0) tick();
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL frame h=%0d v=%0d got=%h exp=%h", mh, mv, act_vec, exp_vec());
      end
      total++;
      hs_lo += (s_hs === 1'b0) ? 1 : 0;
      vs_lo += (s_vs === 1'b0) ? 1 : 0;
      de_hi += (s_de === 1'b1) ? 1 : 0;
    end
    if (hs_lo != HS * VT) begin bad++; $display("FAIL hsync_count got=%0d exp=%0d", hs_lo, HS * VT); end
    total++;
    if (vs_lo != VS * HT) begin bad++; $display("FAIL vsync_count got=%0d exp=%0d", vs_lo, VS * HT); end
    total++;
    if (de_hi != HA * VA) begin bad++; $display("FAIL de_count got=%0d exp=%0d", de_hi, HA * VA); end
    total++;
  endtask

  // full-size raster: active starts at hcnt 260
  task automatic test_hwindow_default();
    int rel[7]  = '{63, 64, 66, 67, 1215, 1279, 1280};
    int ectr[7] = '{0, 0, 2, 0, 2, 0, 0};
    int elb[7]  = '{0, 0, 0, 1, 383, 383, 0};
    int found, pos, hs_lo;
    found = 0; hs_lo = 0;
    for (int n = 0; n < 1650; n++) begin
      tick();
      pos = (cyc - 1) % 1650;
      hs_lo += (d_hs === 1'b0) ? 1 : 0;
      for (int k = 0; k < 7; k++) begin
        if (pos == 260 + rel[k]) begin
          found++;
          if ({d_hcnt, d_hctr, d_hlb} !== {11'(pos), 3'(ectr[k]), 9'(elb[k])}) begin
            bad++;
            $display("FAIL hwin_px%0d hcnt=%0d hctr=%0d hlb=%0d exp %0d/%0d/%0d",
                     rel[k], d_hcnt, d_hctr, d_hlb, pos, ectr[k], elb[k]);
          end
          total++;
        end
      end
    end
    if (found != 7) begin bad++; $display("FAIL hwin_points found=%0d exp=7", found); end
    total++;
    if (hs_lo != 40) begin bad++; $display("FAIL hsync_dflt_line got=%0d exp=40", hs_lo); end
    total++;
  endtask

  // window opens at line 8; ring of 4 entries, 3 lines per step
  task automatic test_vring();
    int ln[5]   = '{8, 10, 11, 19, 20};
    int ectr[5] = '{0, 2, 0, 2, 0};
    int elb[5]  = '{0, 0, 1, 3, 0};
    int found;
    found = 0;
    for (int n = 0; n < HT * VT + HT; n++) begin
      tick();
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL vring_cycle h=%0d v=%0d got=%h exp=%h", mh, mv, act_vec, exp_vec());
      end
      total++;
      if (mh == HT / 2) begin
        for (int k = 0; k < 5; k++) begin
          if (mv == ln[k]) begin
            found++;
            if ({s_vcnt, s_vctr, s_vlb} !== {11'(ln[k]), 3'(ectr[k]), 6'(elb[k])}) begin
              bad++;
              $display("FAIL vring_line%0d vcnt=%0d vctr=%0d vlb=%0d exp %0d/%0d/%0d",
                       ln[k], s_vcnt, s_vctr, s_vlb, ln[k], ectr[k], elb[k]);
            end
            total++;
          end
        end
      end
    end
    if (found < 5) begin bad++; $display("FAIL vring_points found=%0d exp>=5", found); end
    total++;
  endtask

`ifdef FRAMELOCK_EN
  task automatic test_lock();
    int n;
    bit seen;
    n = 0;
    while (!(mv == 20 && mh == HT / 2) && n < 2 * HT * VT) begin tick(); n++; end
    if (n >= 2 * HT * VT) begin bad++; $display("FAIL lock_seek timeout got=%0d", n); end
    total++;
    VSYNC_in = 1'b0;
    arm = 1;
    seen = 0;
    for (int i = 0; i < 2 * HT && !seen; i++) begin
      tick();
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL lock_cycle h=%0d v=%0d got=%h exp=%h", mh, mv, act_vec, exp_vec());
      end
      total++;
      if (s_lock === 1'b1) begin
        seen = 1;
        if ({s_vcnt, s_hcnt} !== {11'(VLOCK), 11'd0}) begin
          bad++; $display("FAIL lock_reload vcnt=%0d hcnt=%0d exp %0d/0", s_vcnt, s_hcnt, VLOCK);
        end
        total++;
      end
    end
    if (!seen) begin bad++; $display("FAIL lock_event not seen exp=1"); end
    total++;
    tick();
    if (s_lock !== 1'b0) begin bad++; $display("FAIL lock_pulse_width got=%b exp=0", s_lock); end
    total++;
    VSYNC_in = 1'b1;
    for (int i = 0; i < 4 * HT; i++) begin
      tick();
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL lock_after h=%0d v=%0d got=%h exp=%h", mh, mv, act_vec, exp_vec());
      end
      total++;
    end
  endtask
`else
  task automatic test_no_lock();
    int hits;
    hits = 0;
    for (int i = 0; i < 3 * HT; i++) begin
      tick();
      if (i % 5 == 0) VSYNC_in = ~VSYNC_in;
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL nolock_cycle h=%0d v=%0d got=%h exp=%h", mh, mv, act_vec, exp_vec());
      end
      total++;
      hits += (s_lock === 1'b1) ? 1 : 0;
    end
    VSYNC_in = 1'b1;
    if (hits != 0) begin bad++; $display("FAIL nolock_events got=%0d exp=0", hits); end
    total++;
  endtask
`endif

  task automatic test_reset_midframe();
    int n;
    n = 0;
    while (!(mv == 40 && mh == 20) && n < 2 * HT * VT) begin tick(); n++; end
    if (n >= 2 * HT * VT) begin bad++; $display("FAIL rst_seek timeout got=%0d", n); end
    total++;
    VSYNC_in = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset_n = 1'b0;
    #1;
    if (act_vec !== {11'd0, 11'd0, 9'd0, 6'd0, 3'd0, 3'd0, 4'b1100}) begin
      bad++; $display("FAIL rst_immediate got=%h exp=%h", act_vec, {47'd0} | 47'b1100);
    end
    total++;
    if ({d_hcnt, d_hs, d_vs, d_de} !== {11'd0, 3'b110}) begin
      bad++; $display("FAIL rst_immediate_dflt hcnt=%0d hs=%b vs=%b de=%b", d_hcnt, d_hs, d_vs, d_de);
    end
    total++;
    VSYNC_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    reset_n = 1'b1;
    for (int i = 0; i < HT * VT + HT; i++) begin
      tick();
      if (act_vec !== exp_vec()) begin
        bad++; $display("FAIL rst_after h=%0d v=%0d got=%h exp=%h", mh, mv, act_vec, exp_vec());
      end
      total++;
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_hwindow_default();
    test_vring();
`ifdef FRAMELOCK_EN
    test_lock();
`else
    test_no_lock();
`endif
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
